// File: rtl/ctrl_pipe_pkg.sv
// Shared types for the control pipeline: the decoded control bundle,
// RV32I major opcodes and the forwarding select encoding.
package ctrl_pkg;

  localparam int CTRL_ALUOP_W = 2;

  typedef struct packed {
    logic                    ALUSrc;
    logic                    MemtoReg;
    logic                    RegWrite;
    logic                    MemRead;
    logic                    MemWrite;
    logic [CTRL_ALUOP_W-1:0] ALUOp;
    logic                    Branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/ctrl_pipe_fwd_unit.sv
// EX-stage operand forwarding selects, derived purely from the registered
// EX/MEM and MEM/WB destinations. EX/MEM is the younger result and wins.
module fwd_unit
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ex_rs1_i,
  input  logic [REG_W-1:0] ex_rs2_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             mem_regwrite_i,
  input  logic             wb_regwrite_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o
);

  // x0 is hardwired zero, so a write to it is never a forwarding source
  function automatic fwd_sel_t select_src(input logic [REG_W-1:0] src);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_o = select_src(ex_rs1_i);
    fwd_b_o = select_src(ex_rs2_i);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall,
// taken-branch flush and EX operand forwarding selects.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  ctrl_t            id_ctrl,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             ex_branch_taken,
  output ctrl_t            ex_ctrl,
  output ctrl_t            mem_ctrl,
  output ctrl_t            wb_ctrl,
  output logic [REG_W-1:0] ex_rs1,
  output logic [REG_W-1:0] ex_rs2,
  output logic [REG_W-1:0] ex_rd,
  output logic [REG_W-1:0] mem_rd,
  output logic [REG_W-1:0] wb_rd,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  if (ALUOP_W != CTRL_ALUOP_W) begin : g_aluop_w_check
    $error("ctrl_pipe: ALUOP_W must match ctrl_pkg::CTRL_ALUOP_W");
  end

  ctrl_t            ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, wb_ctrl_q;
  logic [REG_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic [REG_W-1:0] mem_rd_q, wb_rd_q;
  logic             hazard;
  logic             load_id;

  // Flush is masked during reset so the pipeline reports a fully quiet state
  always_comb begin
    hazard  = id_valid && ex_ctrl_q.MemRead && (ex_rd_q != '0) &&
              ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    flush   = ex_branch_taken && reset;
    stall   = hazard && !ex_branch_taken;
    load_id = id_valid && !hazard && !ex_branch_taken;
  end

  always_comb begin
    ex_ctrl_d = CTRL_NOP;
    ex_rs1_d  = '0;
    ex_rs2_d  = '0;
    ex_rd_d   = '0;
    if (load_id) begin
      ex_ctrl_d = id_ctrl;
      ex_rs1_d  = id_rs1;
      ex_rs2_d  = id_rs2;
      ex_rd_d   = id_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_ctrl_q  <= CTRL_NOP;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      mem_ctrl_q <= CTRL_NOP;
      mem_rd_q   <= '0;
      wb_ctrl_q  <= CTRL_NOP;
      wb_rd_q    <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
      mem_ctrl_q <= ex_ctrl_q;
      mem_rd_q   <= ex_rd_q;
      wb_ctrl_q  <= mem_ctrl_q;
      wb_rd_q    <= mem_rd_q;
    end
  end

  fwd_unit #(
    .REG_W(REG_W)
  ) u_fwd_unit (
    .ex_rs1_i      (ex_rs1_q),
    .ex_rs2_i      (ex_rs2_q),
    .mem_rd_i      (mem_rd_q),
    .wb_rd_i       (wb_rd_q),
    .mem_regwrite_i(mem_ctrl_q.RegWrite),
    .wb_regwrite_i (wb_ctrl_q.RegWrite),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b)
  );

  assign ex_ctrl  = ex_ctrl_q;
  assign ex_rs1   = ex_rs1_q;
  assign ex_rs2   = ex_rs2_q;
  assign ex_rd    = ex_rd_q;
  assign mem_ctrl = mem_ctrl_q;
  assign mem_rd   = mem_rd_q;
  assign wb_ctrl  = wb_ctrl_q;
  assign wb_rd    = wb_rd_q;

endmodule
